block_fetcher: RTL and testbench
================================

// Module: block_fetcher
// PURPOSE
//  Stage directly upstream of intra 4x4 prediction: on start, reads one 4x4 luma block plus its 13
//  neighbours (A-H top/top-right, M corner, I-L left) from the frame store, one pixel per cycle.
//  Substitutes unavailable neighbours and presents the set, held, to the mode/residual stages
//  under a valid/ready handshake.
// PARAMETERS
//  FRAME_W  176  frame width in pixels (multiple of 4)
//  FRAME_H  144  frame height in pixels (multiple of 4)
//  ADDR_W   15   frame-store address width (>= clog2(FRAME_W*FRAME_H))
// PORTS
//  clk         in   1        clock, all state on rising edge
//  reset       in   1        asynchronous, active-low reset
//  enable      in   1        low: FSM and read issue freeze; in-flight read data still captured
//  start       in   1        request fetch of block (blk_x,blk_y); accepted only in IDLE
//  blk_x       in   6        block column, 0..FRAME_W/4-1
//  blk_y       in   6        block row, 0..FRAME_H/4-1
//  busy        out  1        high from accepted start until handshake completes
//  mem_rd      out  1        frame-store read strobe
//  mem_addr    out  ADDR_W   pixel address = y*FRAME_W + x
//  mem_rdata   in   8        read data, valid exactly 1 cycle after mem_rd
//  out_valid   out  1        block + neighbours valid and held
//  out_ready   in   1        consumer accepts when out_valid & out_ready
//  mb          out  128      16 pixels, raster order, pixel 0 in [7:0]
//  toppixels   out  64       A..H, A in [7:0]
//  leftpixels  out  40       M,I,J,K,L, M in [7:0]
//  avail       out  3        {topright, left, top} availability of the delivered block
// BEHAVIOUR
//  Reset: FSM IDLE; busy, mem_rd, out_valid = 0; mem_addr, mb, toppixels, leftpixels, avail = 0.
//  FSM: IDLE -(start)-> FETCH -(last read issued)-> DRAIN -(last data captured)-> HOLD -(out_ready)-> IDLE.
//  Availability: top = blk_y>0; left = blk_x>0; topright = top & (blk_x < FRAME_W/4-1).
//  Read order: 16 block pixels row by row; then A-D if top; E-H if topright; M if top&left;
//   I-L if left. Unavailable pixels are not read. Reads issue back-to-back, one per enabled cycle.
//  Substitution: top unavailable -> A-H = 128; topright unavailable but top available -> E-H = D;
//   left unavailable -> I-L = 128; M unavailable -> 128.
//  Latency, enable held high: 16 reads (corner block 0,0) to 29 reads (interior), + 1 drain cycle;
//   out_valid rises the cycle after the last capture. Interior block: start at cycle 0 ->
//   out_valid high at cycle 31.
//  Handshake: outputs stable while out_valid & ~out_ready. IDLE re-entered on the accepting edge;
//   a start coincident with that edge is ignored (earliest new start is the next cycle).
//  start while busy: ignored, no error. blk_x/blk_y sampled only on accepted start.
//  Out-of-range blk_x/blk_y: undefined result; bench must not drive.
//  enable low during FETCH: mem_rd = 0, read pointer holds; capture of a read issued last cycle
//   still occurs. enable low in HOLD: out_valid stays asserted.
//  Reset asserted mid-fetch: immediate return to reset values; pending read data discarded.
// CONFIGURATION
//  BLOCK_FETCHER_STATS_EN defined: adds output blk_count[15:0], incremented on each accepted
//   handshake, wraps 0xFFFF->0, reset 0. Undefined: port and counter absent; behaviour otherwise identical.
// STRUCTURE
//  intrapred_pkg: PIX_W=8, DC_FILL=8'd128, NEIGH_TOP=8, NEIGH_LEFT=5, fetch-state enum.
//  Sub-module block_addr_gen: read index + availability -> (x,y) -> mem_addr. Incremental
//   row-base add, no multiplier in the loop.
// TESTING
//  Interior (5,3), mem[a]=a[7:0] -> 29 reads; mb[0] = (12*176+20)&FF; out_valid at cycle 31.
//  Corner (0,0) -> 16 reads only; A-H = 128, M = 128, I-L = 128, avail = 3'b000.
//  Right edge (43,2) -> E-H all equal D, avail = 3'b011, 25 reads.
//  out_ready low 10 cycles in HOLD; start pulsed meanwhile -> outputs stable, start ignored, one delivery.
//  enable toggled every other cycle during FETCH -> same data as the enable-high run; mem_rd never
//   high with enable low.
//  reset pulled low at read 7, then restart (1,1) -> clean delivery; with STATS_EN blk_count = 1.

Source files
------------

// File: rtl/intrapred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intrapred_pkg
// Description : Shared constants, fetch-state encoding and read-slot helpers
//               for the intra 4x4 block fetcher.
// Revision    : 1.0 - initial release
// ============================================================================
package intrapred_pkg;

  localparam int         PIX_W      = 8;
  localparam logic [7:0] DC_FILL    = 8'd128;
  localparam int         NEIGH_TOP  = 8;
  localparam int         NEIGH_LEFT = 5;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HOLD  = 2'd3
  } fetch_state_e;

  // Read slots: 0-15 block pixels, 16-19 A-D, 20-23 E-H, 24 M, 25-28 I-L.
  localparam int         SLOT_W        = 5;
  localparam logic [4:0] SLOT_BLK_LAST = 5'd15;
  localparam logic [4:0] SLOT_TOP      = 5'd16;
  localparam logic [4:0] SLOT_TR       = 5'd20;
  localparam logic [4:0] SLOT_M        = 5'd24;
  localparam logic [4:0] SLOT_LEFT     = 5'd25;
  localparam logic [4:0] SLOT_END      = 5'd29;
  localparam logic [4:0] SLOT_DONE     = 5'd31;

  // av = {topright, left, top}
  function automatic logic slot_needed(input logic [4:0] s, input logic [2:0] av);
    logic r;
    if (s < SLOT_TOP)       r = 1'b1;
    else if (s < SLOT_TR)   r = av[0];
    else if (s < SLOT_M)    r = av[2];
    else if (s == SLOT_M)   r = av[0] & av[1];
    else if (s < SLOT_END)  r = av[1];
    else                    r = 1'b0;
    return r;
  endfunction

  // Next slot that actually has to be read, or SLOT_DONE when none is left.
  function automatic logic [4:0] next_slot(input logic [4:0] s, input logic [2:0] av);
    logic [4:0] n;
    n = SLOT_DONE;
    for (int i = 28; i >= 0; i--) begin
      if ((5'(i) > s) && slot_needed(5'(i), av)) n = 5'(i);
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/block_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : block_addr_gen
// Description : Converts the current read slot of a 4x4 block fetch into a
//               frame-store address. Row bases advance by an add of FRAME_W,
//               so the per-pixel path contains no multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module block_addr_gen
  import intrapred_pkg::*;
#(
  parameter int FRAME_W = 176,
  parameter int ADDR_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [5:0]        blk_x,
  input  logic [5:0]        blk_y,
  input  logic              advance,
  input  logic [4:0]        slot,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [ADDR_W-1:0] c_ROW_STEP     = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W-1:0] c_BLK_ROW_STEP = ADDR_W'(4 * FRAME_W);

  logic [ADDR_W-1:0] r_origin;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] w_origin;
  logic [ADDR_W-1:0] w_top_row;

  // Block origin, evaluated once per accepted start (constant coefficient).
  assign w_origin  = ADDR_W'(blk_y) * c_BLK_ROW_STEP + ADDR_W'({blk_x, 2'b00});
  assign w_top_row = r_origin - c_ROW_STEP;

  // Address of the slot being issued this cycle.
  always_comb begin
    addr = r_row_base;
    if (slot < SLOT_TOP)      addr = r_row_base + ADDR_W'(slot[1:0]);
    else if (slot < SLOT_M)   addr = w_top_row + ADDR_W'(slot[2:0]);
    else if (slot == SLOT_M)  addr = w_top_row - ADDR_W'(1);
    else                      addr = r_row_base - ADDR_W'(1);
  end

  // Row base walks the block rows, rewinds to the origin for the left column.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_origin   <= '0;
      r_row_base <= '0;
    end else if (load) begin
      r_origin   <= w_origin;
      r_row_base <= w_origin;
    end else if (advance) begin
      if (slot < SLOT_TOP) begin
        if (slot[1:0] == 2'b11)
          r_row_base <= (slot == SLOT_BLK_LAST) ? r_origin : r_row_base + c_ROW_STEP;
      end else if (slot >= SLOT_LEFT) begin
        r_row_base <= r_row_base + c_ROW_STEP;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/block_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : block_fetcher
// Description : Fetches a 4x4 luma block and its 13 intra neighbours from the
//               frame store one pixel per cycle, fills unavailable neighbours
//               and holds the set under a valid/ready handshake.
//               Optional macro BLOCK_FETCHER_STATS_EN adds blk_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module block_fetcher
  import intrapred_pkg::*;
#(
  parameter int FRAME_W = 176,
  parameter int FRAME_H = 144,
  parameter int ADDR_W  = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          start,
  input  logic [5:0]                    blk_x,
  input  logic [5:0]                    blk_y,
  output logic                          busy,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [PIX_W-1:0]              mem_rdata,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [16*PIX_W-1:0]           mb,
  output logic [NEIGH_TOP*PIX_W-1:0]    toppixels,
  output logic [NEIGH_LEFT*PIX_W-1:0]   leftpixels,
`ifdef BLOCK_FETCHER_STATS_EN
  output logic [15:0]                   blk_count,
`endif
  output logic [2:0]                    avail
);

  localparam logic [1:0] c_ST_IDLE  = 2'(FS_IDLE);
  localparam logic [1:0] c_ST_FETCH = 2'(FS_FETCH);
  localparam logic [1:0] c_ST_DRAIN = 2'(FS_DRAIN);
  localparam logic [1:0] c_ST_HOLD  = 2'(FS_HOLD);
  localparam logic [5:0] c_LAST_COL = 6'(FRAME_W / 4 - 1);

  if (ADDR_W < $clog2(FRAME_W * FRAME_H)) begin : g_addr_w_check
    $error("ADDR_W too small for frame size");
  end

  logic [1:0]                  r_state;
  logic [4:0]                  r_slot;
  logic [2:0]                  r_avail;
  logic                        r_pend;
  logic [4:0]                  r_pend_slot;
  logic [16*PIX_W-1:0]         r_mb;
  logic [NEIGH_TOP*PIX_W-1:0]  r_top;
  logic [NEIGH_LEFT*PIX_W-1:0] r_left;
  logic [4:0]                  w_next_slot;
  logic [2:0]                  w_av_new;
  logic [ADDR_W-1:0]           w_addr;
  logic                        w_start_acc;
  logic                        w_issue;

  assign w_av_new[0] = (blk_y != 6'd0);
  assign w_av_new[1] = (blk_x != 6'd0);
  assign w_av_new[2] = w_av_new[0] && (blk_x < c_LAST_COL);

  assign w_start_acc = (r_state == c_ST_IDLE) && enable && start;
  assign w_issue     = (r_state == c_ST_FETCH) && enable;
  assign w_next_slot = next_slot(r_slot, r_avail);

  assign busy       = (r_state != c_ST_IDLE);
  assign out_valid  = (r_state == c_ST_HOLD);
  assign mem_rd     = w_issue;
  assign mem_addr   = w_issue ? w_addr : '0;
  assign mb         = r_mb;
  assign toppixels  = r_top;
  assign leftpixels = r_left;
  assign avail      = r_avail;

  block_addr_gen #(
    .FRAME_W (FRAME_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (w_start_acc),
    .blk_x   (blk_x),
    .blk_y   (blk_y),
    .advance (w_issue),
    .slot    (r_slot),
    .addr    (w_addr)
  );

  // Fetch sequencing. The output handshake completes independently of enable
  // so a consumer never sees a block it already took still marked valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_IDLE;
      r_slot  <= '0;
      r_avail <= '0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_start_acc) begin
            r_state <= c_ST_FETCH;
            r_slot  <= '0;
            r_avail <= w_av_new;
          end
        end
        c_ST_FETCH: begin
          if (enable) begin
            r_slot <= w_next_slot;
            if (w_next_slot == SLOT_DONE) r_state <= c_ST_DRAIN;
          end
        end
        c_ST_DRAIN: begin
          if (enable) r_state <= c_ST_HOLD;
        end
        default: begin
          if (out_ready) r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // Capture returning read data by slot; neighbours start out as DC fill.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= 1'b0;
      r_pend_slot <= '0;
      r_mb        <= '0;
      r_top       <= '0;
      r_left      <= '0;
    end else begin
      r_pend      <= w_issue;
      r_pend_slot <= r_slot;
      if (w_start_acc) begin
        r_top  <= {NEIGH_TOP{DC_FILL}};
        r_left <= {NEIGH_LEFT{DC_FILL}};
      end else if (r_pend) begin
        if (r_pend_slot < SLOT_TOP) begin
          r_mb[{r_pend_slot[3:0], 3'b000} +: PIX_W] <= mem_rdata;
        end else if (r_pend_slot < SLOT_M) begin
          r_top[{r_pend_slot[2:0], 3'b000} +: PIX_W] <= mem_rdata;
          // D replicates into E-H when the top-right block is missing.
          if ((r_pend_slot == SLOT_TR - 5'd1) && !r_avail[2])
            r_top[NEIGH_TOP*PIX_W-1:4*PIX_W] <= {4{mem_rdata}};
        end else begin
          r_left[{r_pend_slot[2:0], 3'b000} +: PIX_W] <= mem_rdata;
        end
      end
    end
  end

`ifdef BLOCK_FETCHER_STATS_EN
  logic [15:0] r_blk_count;

  // Delivered-block counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                 r_blk_count <= '0;
    else if ((r_state == c_ST_HOLD) && out_ready) r_blk_count <= r_blk_count + 16'd1;
  end

  assign blk_count = r_blk_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_fetcher
// Description : Self-checking bench for block_fetcher (frame store model
//               returns mem[a] = a[7:0] one cycle after each read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_fetcher;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         start;
  logic [5:0]   blk_x;
  logic [5:0]   blk_y;
  logic         busy;
  logic         mem_rd;
  logic [14:0]  mem_addr;
  logic [7:0]   mem_rdata = 8'h00;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mb;
  logic [63:0]  toppixels;
  logic [39:0]  leftpixels;
  logic [2:0]   avail;
`ifdef BLOCK_FETCHER_STATS_EN
  logic [15:0]  blk_count;
`endif

  block_fetcher #(.FRAME_W(176), .FRAME_H(144), .ADDR_W(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .busy       (busy),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mb         (mb),
    .toppixels  (toppixels),
    .leftpixels (leftpixels),
`ifdef BLOCK_FETCHER_STATS_EN
    .blk_count  (blk_count),
`endif
    .avail      (avail)
  );

  always #5 clk = ~clk;

  int n_reads = 0;
  always @(posedge clk) begin
    mem_rdata <= mem_rd ? mem_addr[7:0] : 8'h00;
    if (mem_rd) n_reads++;
  end

  typedef struct {
    logic [127:0] mb;
    logic [63:0]  top;
    logic [39:0]  left;
    logic [2:0]   av;
  } exp_t;

  typedef struct {
    int         bx;
    int         by;
    int         reads;
    logic [2:0] av;
  } vec_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [7:0] pix(int x, int y);
    int a;
    a = y * 176 + x;
    return a[7:0];
  endfunction

  function automatic exp_t model(int bx, int by);
    exp_t e;
    bit t, l, tr;
    t  = (by > 0);
    l  = (bx > 0);
    tr = t && (bx < 43);
    for (int i = 0; i < 16; i++) e.mb[i*8 +: 8] = pix(4*bx + i%4, 4*by + i/4);
    for (int i = 0; i < 4; i++)  e.top[i*8 +: 8] = t ? pix(4*bx + i, 4*by - 1) : 8'd128;
    for (int i = 4; i < 8; i++)
      e.top[i*8 +: 8] = tr ? pix(4*bx + i, 4*by - 1) : (t ? pix(4*bx + 3, 4*by - 1) : 8'd128);
    e.left[7:0] = (t && l) ? pix(4*bx - 1, 4*by - 1) : 8'd128;
    for (int i = 0; i < 4; i++) e.left[(i+1)*8 +: 8] = l ? pix(4*bx - 1, 4*by + i) : 8'd128;
    e.av = {tr, l, t};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Accept the held block; optionally drive start on the accepting edge.
  task automatic deliver(input bit start_on_accept);
    exp_t e;
    chk("valid_before_accept", 128'(out_valid), 128'(1));
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 128'(0), 128'(1));
      return;
    end
    e = sb.pop_front();
    chk("mb", mb, e.mb);
    chk("toppixels", 128'(toppixels), 128'(e.top));
    chk("leftpixels", 128'(leftpixels), 128'(e.left));
    chk("avail_out", 128'(avail), 128'(e.av));
    out_ready = 1'b1;
    if (start_on_accept) begin
      start = 1'b1; blk_x = 6'd0; blk_y = 6'd0;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    start     = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'(0));
    chk("valid_after_accept", 128'(out_valid), 128'(0));
  endtask

  // Start a fetch, return the cycle at which out_valid is first seen (start = cycle 0).
  task automatic launch(input int bx, input int by, output int cyc);
    sb.push_back(model(bx, by));
    start = 1'b1; blk_x = 6'(bx); blk_y = 6'(by);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("timeout_out_valid", 128'(0), 128'(1));
  endtask

  vec_t         vecs[6];
  int           cyc, r0;
  logic [127:0] snap_mb;
  logic [63:0]  snap_top;

  initial begin
    vecs[0] = '{bx: 5,  by: 3,  reads: 29, av: 3'b111};
    vecs[1] = '{bx: 0,  by: 0,  reads: 16, av: 3'b000};
    vecs[2] = '{bx: 43, by: 2,  reads: 25, av: 3'b011};
    vecs[3] = '{bx: 0,  by: 5,  reads: 24, av: 3'b101};
    vecs[4] = '{bx: 7,  by: 0,  reads: 20, av: 3'b010};
    vecs[5] = '{bx: 43, by: 35, reads: 25, av: 3'b011};

    reset = 1'b0; enable = 1'b1; start = 1'b0; out_ready = 1'b0;
    blk_x = '0; blk_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_mem_rd", 128'(mem_rd), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_mem_addr", 128'(mem_addr), 128'(0));
    chk("rst_mb", mb, 128'(0));
    chk("rst_top", 128'(toppixels), 128'(0));
    chk("rst_left", 128'(leftpixels), 128'(0));
    chk("rst_avail", 128'(avail), 128'(0));
    reset = 1'b1;
    @(posedge clk); #1;

    // Table-driven fetches with enable held high.
    for (int v = 0; v < 6; v++) begin
      r0 = n_reads;
      launch(vecs[v].bx, vecs[v].by, cyc);
      chk("latency", 128'(cyc), 128'(vecs[v].reads + 2));
      chk("read_count", 128'(n_reads - r0), 128'(vecs[v].reads));
      chk("avail_vec", 128'(avail), 128'(vecs[v].av));
      deliver(1'b0);
      @(posedge clk); #1;
    end

    // Stall in HOLD with a stray start; outputs must stay put.
    r0 = n_reads;
    launch(5, 3, cyc);
    chk("interior_cycle31", 128'(cyc), 128'(31));
    snap_mb  = mb;
    snap_top = toppixels;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        start = 1'b1; blk_x = 6'd1; blk_y = 6'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      chk("stall_valid", 128'(out_valid), 128'(1));
      chk("stall_mb", mb, snap_mb);
      chk("stall_top", 128'(toppixels), 128'(snap_top));
    end
    start = 1'b0;
    deliver(1'b1);
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid || busy) begin
        chk("extra_delivery", 128'(1), 128'(0));
        break;
      end
    end
    chk("stall_reads", 128'(n_reads - r0), 128'(29));

    // Enable toggling during fetch: same result, no read while enable low.
    sb.push_back(model(5, 3));
    start = 1'b1; blk_x = 6'd5; blk_y = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      enable = ~enable;
      #1;
      if (!enable) chk("rd_while_disabled", 128'(mem_rd), 128'(0));
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) chk("timeout_toggle", 128'(0), 128'(1));
    enable = 1'b1;
    deliver(1'b0);
    @(posedge clk); #1;

    // Reset in the middle of a fetch, then a clean restart.
    sb.push_back(model(5, 3));
    r0 = n_reads;
    start = 1'b1; blk_x = 6'd5; blk_y = 6'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while ((n_reads - r0) < 7 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_mem_rd", 128'(mem_rd), 128'(0));
    chk("midrst_addr", 128'(mem_addr), 128'(0));
    chk("midrst_mb", mb, 128'(0));
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    r0 = n_reads;
    launch(1, 1, cyc);
    chk("restart_latency", 128'(cyc), 128'(31));
    chk("restart_reads", 128'(n_reads - r0), 128'(29));
    deliver(1'b0);
`ifdef BLOCK_FETCHER_STATS_EN
    chk("blk_count", 128'(blk_count), 128'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
